hpu_phase_ctrl: RTL and testbench
=================================

// Module: hpu_phase_ctrl
// PURPOSE
//  Sequences one HPU job with no per-phase software writes: item-memory generation (matw), stream
//  execution (run), output drain, done. Sits between the AXI-Lite register file and the AXIS
//  datapath (src/s/exe/dst ctrl, core, xorshift), driving matw/run/last/mat_a in their clock domain.
// PARAMETERS
//  MAT_AW   7      width of mat_a item-memory write address
//  ITEM_W   16     width of item count (max 65536 entries)
//  BEAT_W   20     width of input beat counter
//  WDOG_W   24     watchdog counter width (HPU_PHASE_WDOG_EN only)
// PORTS
//  AXIS_ACLK     in   1        sole clock
//  AXIS_ARESETN  in   1        async active-low reset
//  cfg_start     in   1        1-cycle start pulse (accepted in IDLE/DONE only)
//  cfg_abort     in   1        1-cycle abort pulse, any state
//  cfg_item_num  in   ITEM_W   last item index to generate (entries = value+1)
//  cfg_beats     in   BEAT_W   expected S_AXIS beats for the job
//  cfg_last      in   1        job-is-final flag, forwarded as last
//  src_v         in   1        S_AXIS beat accepted
//  s_fin         in   1        exe_ctrl finished pulse
//  dst_hs_last   in   1        M_AXIS TVALID&TREADY&TLAST
//  matw          out  1        item-memory generation enable
//  run           out  1        datapath run enable
//  last          out  1        registered cfg_last for current job
//  mat_a         out  MAT_AW   item-memory write address
//  busy          out  1        state not IDLE/DONE
//  done          out  1        sticky job-complete
//  err           out  2        {wdog_timeout, beat_mismatch}, sticky
//  beat_cnt      out  BEAT_W   beats accepted this job (saturating)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0. Every output registered.
//  - States: IDLE -> GEN -> GAP -> RUN -> DRAIN -> DONE.
//  - IDLE/DONE: cfg_start -> GEN next cycle; captures cfg_item_num/cfg_beats/cfg_last; clears done,
//    err, beat_cnt, mat_a, item counter. cfg_start elsewhere ignored.
//  - GEN: matw=1; item counter (ITEM_W) and mat_a +1 per cycle; mat_a = low MAT_AW bits (wraps
//    naturally). Counter == item_num -> GAP; exactly item_num+1 matw cycles (item_num=0 -> one).
//  - GAP: one cycle, matw=run=0, lets xorshift/core settle. -> RUN.
//  - RUN: run=1; beat_cnt +1 per src_v, saturates at all-ones. s_fin -> DRAIN; beat_mismatch set if
//    beat_cnt (incl. same-cycle src_v) != cfg_beats.
//  - DRAIN: run=1 held (dst_ctrl gated by run); dst_hs_last -> DONE; run drops next cycle.
//  - s_fin and dst_hs_last same cycle in RUN: go straight to DONE.
//  - DONE: done=1, busy=0, run=matw=0; holds until next cfg_start.
//  - cfg_abort: any state -> IDLE next cycle, matw/run/busy=0; done not set; err/beat_cnt kept.
//    Abort with start same cycle: abort wins.
//  - busy=1 exactly while in GEN/GAP/RUN/DRAIN.
// CONFIGURATION
//  - HPU_PHASE_WDOG_EN defined: WDOG_W counter clears on state change and on src_v/dst_hs_last,
//    counts in RUN/DRAIN; terminal all-ones -> err[1]=1, state IDLE (as abort).
//  - Undefined: no counter, err[1] tied 0, RUN/DRAIN wait forever.
// STRUCTURE
//  - hpu_pkg: phase_e state enum (IDLE,GEN,GAP,RUN,DRAIN,DONE), ERR_* bit indices, default widths.
//  - Sub-module hpu_wdog (clear/enable/timeout) instanced only under HPU_PHASE_WDOG_EN; FSM and
//    counters otherwise in one always_ff.
// TESTING
//  - Reset mid-RUN: drop AXIS_ARESETN async -> all outputs 0 immediately, state IDLE.
//  - item_num=99, beats=8: matw high 100 cycles, mat_a 0..99 (wraps at 127 ok), 1 gap, run, 8 src_v,
//    s_fin, dst_hs_last -> done=1, err=0, beat_cnt=8.
//  - item_num=0: matw exactly 1 cycle, mat_a=0.
//  - beats=8, 7 src_v then s_fin -> err[0]=1, done still reaches 1 after dst_hs_last.
//  - cfg_abort in GEN at mat_a=40 -> matw=0 next cycle, busy=0, done=0; new start restarts mat_a=0.
//  - WDOG_EN, WDOG_W=8, stall in RUN 255 cycles -> err[1]=1, run=0, state IDLE; start ignored in RUN.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared types and default widths for the HPU phase controller.
package hpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    GAP   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } phase_e;

  localparam int ERR_BEAT = 0;
  localparam int ERR_WDOG = 1;

  localparam int MAT_AW_DEF = 7;
  localparam int ITEM_W_DEF = 16;
  localparam int BEAT_W_DEF = 20;
  localparam int WDOG_W_DEF = 24;

endpackage

// File: rtl/hpu_wdog.sv
// Inactivity watchdog: counts while enabled, raises timeout at the all-ones terminal count.
module hpu_wdog #(
  parameter int W = 24
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Activity in the terminal cycle rescues the job.
  assign timeout_o = en_i && !clr_i && (cnt_q == '1);

endmodule

// File: rtl/hpu_phase_ctrl.sv
// HPU job sequencer: item-memory generation, stream run, output drain, done.
// Optional watchdog on RUN/DRAIN stalls is built when HPU_PHASE_WDOG_EN is defined.
//
// state | meaning
// IDLE  | no job, waiting for cfg_start
// GEN   | matw=1, writing item memory, mat_a stepping
// GAP   | one settle cycle before run
// RUN   | run=1, counting S_AXIS beats until s_fin
// DRAIN | run=1 held until the final M_AXIS beat
// DONE  | job complete, done=1 until next cfg_start
module hpu_phase_ctrl
  import hpu_pkg::*;
#(
  parameter int MAT_AW = MAT_AW_DEF,
  parameter int ITEM_W = ITEM_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
`ifdef HPU_PHASE_WDOG_EN
  , parameter int WDOG_W = WDOG_W_DEF
`endif
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [BEAT_W-1:0] cfg_beats,
  input  logic              cfg_last,
  input  logic              src_v,
  input  logic              s_fin,
  input  logic              dst_hs_last,
  output logic              matw,
  output logic              run,
  output logic              last,
  output logic [MAT_AW-1:0] mat_a,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [BEAT_W-1:0] beat_cnt
);

  phase_e            state_q;
  logic [ITEM_W-1:0] item_num_q, item_cnt_q;
  logic [BEAT_W-1:0] beats_q, beat_cnt_q, beat_cnt_d;
  logic [MAT_AW-1:0] mat_a_q;
  logic              matw_q, run_q, last_q, busy_q, done_q;
  logic [1:0]        err_q;
  logic              wdog_to;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (src_v && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + 1'b1;
  end

`ifdef HPU_PHASE_WDOG_EN
  logic wdog_en, wdog_clr;
  assign wdog_en  = (state_q == RUN) || (state_q == DRAIN);
  assign wdog_clr = !wdog_en || src_v || dst_hs_last || cfg_abort ||
                    ((state_q == RUN) && s_fin);

  hpu_wdog #(.W(WDOG_W)) u_wdog (
    .clk_i    (AXIS_ACLK),
    .rst_n_i  (AXIS_ARESETN),
    .clr_i    (wdog_clr),
    .en_i     (wdog_en),
    .timeout_o(wdog_to)
  );
`else
  assign wdog_to = 1'b0;
`endif

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= IDLE;
      item_num_q <= '0;
      item_cnt_q <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      mat_a_q    <= '0;
      matw_q     <= 1'b0;
      run_q      <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else if (cfg_abort || wdog_to) begin
      state_q <= IDLE;
      matw_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      if (!cfg_abort) err_q[ERR_WDOG] <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (cfg_start) begin
            state_q    <= GEN;
            item_num_q <= cfg_item_num;
            beats_q    <= cfg_beats;
            last_q     <= cfg_last;
            item_cnt_q <= '0;
            mat_a_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            matw_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        GEN: begin
          if (item_cnt_q == item_num_q) begin
            state_q <= GAP;
            matw_q  <= 1'b0;
          end else begin
            item_cnt_q <= item_cnt_q + 1'b1;
            mat_a_q    <= mat_a_q + 1'b1;
          end
        end
        GAP: begin
          state_q <= RUN;
          run_q   <= 1'b1;
        end
        RUN: begin
          beat_cnt_q <= beat_cnt_d;
          if (s_fin) begin
            if (beat_cnt_d != beats_q) err_q[ERR_BEAT] <= 1'b1;
            if (dst_hs_last) begin
              state_q <= DONE;
              run_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dst_hs_last) begin
            state_q <= DONE;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          matw_q  <= 1'b0;
          run_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign matw     = matw_q;
  assign run      = run_q;
  assign last     = last_q;
  assign mat_a    = mat_a_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_hpu_phase_ctrl.sv
// Self-checking bench for hpu_phase_ctrl: directed job table, corner sequences, random jobs.
module tb_hpu_phase_ctrl;

  localparam int MAT_AW = 7;
  localparam int ITEM_W = 16;
  localparam int BEAT_W = 4;  // narrow so beat_cnt saturation is reachable

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0, cfg_abort = 1'b0, cfg_last = 1'b0;
  logic [ITEM_W-1:0] cfg_item_num = '0;
  logic [BEAT_W-1:0] cfg_beats = '0;
  logic              src_v = 1'b0, s_fin = 1'b0, dst_hs_last = 1'b0;
  logic              matw, run, last, busy, done;
  logic [MAT_AW-1:0] mat_a;
  logic [1:0]        err;
  logic [BEAT_W-1:0] beat_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hpu_phase_ctrl #(
    .MAT_AW(MAT_AW), .ITEM_W(ITEM_W), .BEAT_W(BEAT_W)
`ifdef HPU_PHASE_WDOG_EN
    , .WDOG_W(8)
`endif
  ) dut (
    .AXIS_ACLK   (clk),
    .AXIS_ARESETN(rst_n),
    .cfg_start   (cfg_start),
    .cfg_abort   (cfg_abort),
    .cfg_item_num(cfg_item_num),
    .cfg_beats   (cfg_beats),
    .cfg_last    (cfg_last),
    .src_v       (src_v),
    .s_fin       (s_fin),
    .dst_hs_last (dst_hs_last),
    .matw        (matw),
    .run         (run),
    .last        (last),
    .mat_a       (mat_a),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .beat_cnt    (beat_cnt)
  );

  typedef struct {
    int item;
    int beats;
    int nsrc;
    bit lst;
    bit fin_src;
    bit same;
    int exp_matw;
    int exp_beat;
    int exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input int item, input int beats, input int nsrc, input bit lst,
                         input bit fin_src, input bit same, input int exp_matw,
                         input int exp_beat, input int exp_err, input string tag);
    int ncyc, aerr, k;
    cfg_item_num = ITEM_W'(item);
    cfg_beats    = BEAT_W'(beats);
    cfg_last     = lst;
    cfg_start    = 1'b1;
    tick();
    cfg_start    = 1'b0;
    cfg_item_num = ITEM_W'($urandom);
    cfg_beats    = BEAT_W'($urandom);
    cfg_last     = ~lst;
    chk($sformatf("%s.start_busy", tag), 32'(busy), 32'd1);
    chk($sformatf("%s.start_clears", tag), 32'({done, err, beat_cnt}), 32'd0);
    ncyc = 0;
    aerr = 0;
    while (matw === 1'b1 && ncyc < item + 5) begin
      if (mat_a !== MAT_AW'(ncyc % 128)) aerr++;
      ncyc++;
      tick();
    end
    chk($sformatf("%s.matw_cycles", tag), 32'(ncyc), 32'(exp_matw));
    chk($sformatf("%s.mat_a_seq_errs", tag), 32'(aerr), 32'd0);
    chk($sformatf("%s.gap_busy_run_matw", tag), 32'({busy, run, matw}), 32'b100);
    tick();
    chk($sformatf("%s.run_up", tag), 32'(run), 32'd1);
    k = fin_src ? nsrc - 1 : nsrc;
    for (int i = 0; i < k; i++) begin
      src_v = 1'b1;
      tick();
      src_v = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    s_fin       = 1'b1;
    src_v       = fin_src;
    dst_hs_last = same;
    tick();
    s_fin       = 1'b0;
    src_v       = 1'b0;
    dst_hs_last = 1'b0;
    if (!same) begin
      chk($sformatf("%s.drain_run_busy", tag), 32'({run, busy}), 32'b11);
      repeat ($urandom_range(0, 3)) tick();
      dst_hs_last = 1'b1;
      tick();
      dst_hs_last = 1'b0;
    end
    chk($sformatf("%s.done", tag), 32'({done, busy, run, matw}), 32'b1000);
    chk($sformatf("%s.beat_cnt", tag), 32'(beat_cnt), 32'(exp_beat));
    chk($sformatf("%s.err", tag), 32'(err), 32'(exp_err));
    chk($sformatf("%s.last", tag), 32'(last), 32'(lst));
  endtask

  initial begin
    int cnt, item, beats, nsrc, eb;
    bit lst, fs, sm;

    //         item beats nsrc lst fin same matw beat err
    vt[0] = '{  99,   8,   8, 1'b0, 1'b0, 1'b0, 100,  8, 0};
    vt[1] = '{   0,   3,   3, 1'b1, 1'b1, 1'b0,   1,  3, 0};
    vt[2] = '{   5,   8,   7, 1'b0, 1'b0, 1'b0,   6,  7, 1};
    vt[3] = '{ 130,   2,   2, 1'b1, 1'b0, 1'b1, 131,  2, 0};
    vt[4] = '{   2,   0,   0, 1'b0, 1'b0, 1'b0,   3,  0, 0};
    vt[5] = '{   3,   5,   6, 1'b1, 1'b1, 1'b1,   4,  6, 1};
    vt[6] = '{   1,  15,  20, 1'b0, 1'b0, 1'b0,   2, 15, 0};
    vt[7] = '{   4,  14,  20, 1'b0, 1'b1, 1'b0,   5, 15, 1};

    repeat (3) tick();
    chk("reset_outputs", 32'({matw, run, last, mat_a, busy, done, err, beat_cnt}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++)
      run_job(vt[i].item, vt[i].beats, vt[i].nsrc, vt[i].lst, vt[i].fin_src, vt[i].same,
              vt[i].exp_matw, vt[i].exp_beat, vt[i].exp_err, $sformatf("vec%0d", i));

    // Abort during GEN at mat_a == 40
    cfg_item_num = 16'd99;
    cfg_beats    = 4'd1;
    cfg_start    = 1'b1;
    tick();
    cfg_start = 1'b0;
    cnt = 0;
    while (mat_a !== 7'd40 && cnt < 60) begin
      tick();
      cnt++;
    end
    chk("abort.reach_40", 32'({matw, mat_a}), 32'({1'b1, 7'd40}));
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort.outputs", 32'({matw, run, busy, done}), 32'd0);
    cfg_abort = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
    chk("abort_wins.same_cycle", 32'({busy, matw}), 32'd0);
    tick();
    chk("abort_wins.still_idle", 32'(busy), 32'd0);
    run_job(10, 1, 1, 1'b1, 1'b0, 1'b0, 11, 1, 0, "restart");

    // Start ignored in RUN; stall behaviour
    cfg_item_num = 16'd2;
    cfg_beats    = 4'd1;
    cfg_start    = 1'b1;
    tick();
    cfg_start = 1'b0;
    cnt = 0;
    while (run !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("stall.reach_run", 32'(run), 32'd1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("stall.start_ignored", 32'({busy, run, matw}), 32'b110);
`ifdef HPU_PHASE_WDOG_EN
    cnt = 0;
    while (run === 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("wdog.run_dropped", 32'(run), 32'd0);
    chk("wdog.err", 32'(err), 32'b10);
    chk("wdog.idle", 32'({busy, done, matw}), 32'd0);
`else
    repeat (300) tick();
    chk("stall.still_run", 32'({run, busy, err}), 32'b1100);
    src_v       = 1'b1;
    s_fin       = 1'b1;
    dst_hs_last = 1'b1;
    tick();
    src_v       = 1'b0;
    s_fin       = 1'b0;
    dst_hs_last = 1'b0;
    chk("stall.finish", 32'({done, run, err, beat_cnt}), 32'({1'b1, 1'b0, 2'b00, 4'd1}));
`endif

    // Async reset mid-RUN
    cfg_item_num = 16'd2;
    cfg_beats    = 4'd3;
    cfg_last     = 1'b1;
    cfg_start    = 1'b1;
    tick();
    cfg_start = 1'b0;
    cnt = 0;
    while (run !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    src_v = 1'b1;
    tick();
    src_v = 1'b0;
    chk("rst_mid.pre", 32'({run, beat_cnt}), 32'({1'b1, 4'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.async_zero", 32'({matw, run, last, mat_a, busy, done, err, beat_cnt}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mid.idle", 32'({busy, run}), 32'd0);

    // Random jobs against a job-level model
    for (int j = 0; j < 12; j++) begin
      item  = $urandom_range(0, 150);
      beats = $urandom_range(0, 15);
      nsrc  = $urandom_range(0, 20);
      lst   = 1'($urandom_range(0, 1));
      sm    = 1'($urandom_range(0, 1));
      fs    = (nsrc > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      eb    = (nsrc > 15) ? 15 : nsrc;
      run_job(item, beats, nsrc, lst, fs, sm, item + 1, eb, (eb != beats) ? 1 : 0,
              $sformatf("rnd%0d", j));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
